// File: rtl/sao_pkg.sv
// Shared types and width helpers for the SAO distortion stream block.
package sao_pkg;

  // Beat kind carried on o_kind.
  typedef enum logic [1:0] {
    KIND_EO    = 2'd0,
    KIND_BO    = 2'd1,
    KIND_MERGE = 2'd2
  } kind_t;

  // Sweep controller state. Also exported on a debug port.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } sweep_state_t;

  // SAO type encodings for the default four EO classes.
  // With other N_EO_TYPE values, BO is always sao_type_bo(N_EO_TYPE).
  typedef enum logic [2:0] {
    SAO_EO0 = 3'd0,
    SAO_EO1 = 3'd1,
    SAO_EO2 = 3'd2,
    SAO_EO3 = 3'd3,
    SAO_BO  = 3'd4
  } sao_type_t;

  function automatic int sao_type_bo(input int n_eo_type);
    return n_eo_type;
  endfunction

  // Count width: a CTU holds (2^log2)^2 pixels.
  function automatic int num_w(input int ctu_log2);
    return 2 * ctu_log2;
  endfunction

  // Signed sum width: count width plus clipped difference width.
  function automatic int sum_w(input int ctu_log2, input int clip_bit);
    return num_w(ctu_log2) + clip_bit;
  endfunction

  // Number of bands kept below cand_bo in the BO window.
  function automatic int w_lo(input int n_bo_win);
    return n_bo_win / 2 - 1;
  endfunction

  // clog2 with a floor of one bit, so small counts still get a real field.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sao_dist_stream_if.sv
// Output beat stream from sao_dist_stream to the SAO RD-cost datapath.
interface sao_dist_stream_if
  import sao_pkg::*;
#(
  parameter int SUM_W = 14,
  parameter int NUM_W = 10,
  parameter int SEL_W = 2,
  parameter int CAT_W = 3
);
  // Handshake: a beat transfers on every rising edge where o_valid and
  // o_ready are both high. Once o_valid is raised the master holds it and
  // every payload field stable until that transfer; o_valid never depends
  // combinationally on o_ready.
  logic                    o_valid;
  logic                    o_ready;
  logic signed [SUM_W-1:0] o_sum;
  logic [NUM_W-1:0]        o_num;
  kind_t                   o_kind;
  logic [SEL_W-1:0]        o_sel;
  logic [CAT_W-1:0]        o_cat;
  logic                    o_skip;
  logic                    o_last;

  modport master (
    output o_valid, o_sum, o_num, o_kind, o_sel, o_cat, o_skip, o_last,
    input  o_ready
  );

  modport slave (
    input  o_valid, o_sum, o_num, o_kind, o_sel, o_cat, o_skip, o_last,
    output o_ready
  );
endinterface

// File: rtl/sao_merge_bo_remap.sv
// Maps a merge candidate's BO start band into the local BO window.
// hit is high when all N_CATEGORY bands starting at aux lie inside the
// window; idx is then the window slot for category cat.
module sao_merge_bo_remap
  import sao_pkg::*;
#(
  parameter int N_BO_WIN   = 8,
  parameter int N_CATEGORY = 4,
  localparam int IDX_W = clog2_min1(N_BO_WIN),
  localparam int CAT_W = clog2_min1(N_CATEGORY)
) (
  input  logic [4:0]       cand_bo,
  input  logic [4:0]       aux,
  input  logic [CAT_W-1:0] cat,
  output logic             hit,
  output logic [IDX_W-1:0] idx
);
  localparam int W_LO = w_lo(N_BO_WIN);
  localparam logic signed [6:0] D_MIN = 7'(-W_LO);
  localparam logic signed [6:0] D_MAX = 7'(N_BO_WIN - W_LO - N_CATEGORY);
  localparam logic signed [6:0] OFS   = 7'(W_LO);

  logic signed [6:0] d;
  logic signed [6:0] slot;

  // Band distance in 7-bit signed arithmetic so bands never wrap mod 32.
  always_comb begin
    d    = $signed({2'b00, aux}) - $signed({2'b00, cand_bo});
    hit  = (d >= D_MIN) && (d <= D_MAX);
    slot = d + OFS + $signed(7'(cat));
    idx  = IDX_W'(slot);
  end
endmodule

// File: rtl/sao_dist_stream.sv
// Sequential SAO distortion arranger: walks every EO, BO-window and merge
// candidate after a start pulse and emits one (sum, num) beat per step.
module sao_dist_stream
  import sao_pkg::*;
#(
  parameter int NUM_PIX_CTU_LOG2 = 5,
  parameter int DIFF_CLIP_BIT    = 4,
  parameter int N_CATEGORY       = 4,
  parameter int N_EO_TYPE        = 4,
  parameter int N_BO_WIN         = 8,
  parameter int N_MERGE          = 2,
  localparam int NUM_W = num_w(NUM_PIX_CTU_LOG2),
  localparam int SUM_W = sum_w(NUM_PIX_CTU_LOG2, DIFF_CLIP_BIT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic signed [SUM_W-1:0] sum_eo [N_EO_TYPE][N_CATEGORY],
  input  logic [NUM_W-1:0]        num_eo [N_EO_TYPE][N_CATEGORY],
  input  logic signed [SUM_W-1:0] sum_bo [N_BO_WIN],
  input  logic [NUM_W-1:0]        num_bo [N_BO_WIN],
  input  logic [4:0]              cand_bo,
  input  logic [2:0]              merge_type [N_MERGE],
  input  logic [1:0]              merge_mode [N_MERGE],
  input  logic [4:0]              merge_aux [N_MERGE],
  output logic                    busy,
  output logic                    done,
  output sweep_state_t            dbg_state,
  sao_dist_stream_if.master       out_if
);
  localparam int EO_END = N_EO_TYPE * N_CATEGORY;
  localparam int BO_END = EO_END + N_BO_WIN;
  localparam int N_STEP = BO_END + N_MERGE * N_CATEGORY;
  localparam int STEP_W = clog2_min1(N_STEP);
  localparam int SEL_W  = clog2_min1((N_EO_TYPE > N_MERGE) ? N_EO_TYPE : N_MERGE);
  localparam int CAT_W  = clog2_min1(N_BO_WIN);
  localparam int MCAT_W = clog2_min1(N_CATEGORY);

  sweep_state_t      state;
  logic [STEP_W-1:0] step;
  logic [STEP_W-1:0] load_step;
  logic [4:0]        cand_q;
  logic [2:0]        mtype_q [N_MERGE];
  logic [1:0]        mmode_q [N_MERGE];
  logic [4:0]        maux_q  [N_MERGE];

  kind_t                   b_kind;
  int                      s_i, b_sel, b_cat, eo_t, eo_c, bo_i;
  logic                    b_last, b_skip;
  logic signed [SUM_W-1:0] b_sum;
  logic [NUM_W-1:0]        b_num;
  logic [2:0]              m_type;
  logic [1:0]              m_mode;
  logic [4:0]              m_aux;
  logic [MCAT_W-1:0]       m_cat;
  logic                    bo_hit;
  logic [CAT_W-1:0]        bo_idx;
  logic                    xfer, load_en, end_en;

  assign busy      = (state == ST_RUN);
  assign dbg_state = state;
  assign xfer      = (state == ST_RUN) && out_if.o_valid && out_if.o_ready;
  assign end_en    = xfer && out_if.o_last;
  assign load_en   = ((state == ST_IDLE) && start) || (xfer && !out_if.o_last);
  assign load_step = (state == ST_IDLE) ? '0 : step + 1'b1;

  // Decode the step being loaded into beat kind, selector and category.
  // Beat 0 is always EO, so merge context is only read once it is captured.
  always_comb begin
    s_i    = int'(load_step);
    b_kind = KIND_EO;
    b_sel  = 0;
    b_cat  = 0;
    m_type = '0;
    m_mode = '0;
    m_aux  = '0;
    b_last = (s_i == N_STEP - 1);
    if (s_i < EO_END) begin
      b_sel = s_i / N_CATEGORY;
      b_cat = s_i % N_CATEGORY;
    end else if (s_i < BO_END) begin
      b_kind = KIND_BO;
      b_cat  = s_i - EO_END;
    end else begin
      b_kind = KIND_MERGE;
      b_sel  = (s_i - BO_END) / N_CATEGORY;
      b_cat  = (s_i - BO_END) % N_CATEGORY;
      for (int m = 0; m < N_MERGE; m++) begin
        if (m == b_sel) begin
          m_type = mtype_q[m];
          m_mode = mmode_q[m];
          m_aux  = maux_q[m];
        end
      end
    end
    m_cat = MCAT_W'(b_cat);
  end

  sao_merge_bo_remap #(
    .N_BO_WIN   (N_BO_WIN),
    .N_CATEGORY (N_CATEGORY)
  ) u_remap (
    .cand_bo (cand_q),
    .aux     (m_aux),
    .cat     (m_cat),
    .hit     (bo_hit),
    .idx     (bo_idx)
  );

  // Resolve which statistic feeds the beat; unusable merges give zero payload.
  always_comb begin
    eo_t   = -1;
    eo_c   = 0;
    bo_i   = -1;
    b_skip = 1'b0;
    b_sum  = '0;
    b_num  = '0;
    case (b_kind)
      KIND_EO: begin
        eo_t = b_sel;
        eo_c = b_cat;
      end
      KIND_BO: bo_i = b_cat;
      default: begin
        if (m_mode == 2'd0 || int'(m_type) > N_EO_TYPE) begin
          b_skip = 1'b1;
        end else if (int'(m_type) < N_EO_TYPE) begin
          eo_t = int'(m_type);
          eo_c = b_cat;
        end else if (bo_hit) begin
          bo_i = int'(bo_idx);
        end else begin
          b_skip = 1'b1;
        end
      end
    endcase
    for (int t = 0; t < N_EO_TYPE; t++) begin
      for (int c = 0; c < N_CATEGORY; c++) begin
        if (t == eo_t && c == eo_c) begin
          b_sum = sum_eo[t][c];
          b_num = num_eo[t][c];
        end
      end
    end
    for (int i = 0; i < N_BO_WIN; i++) begin
      if (i == bo_i) begin
        b_sum = sum_bo[i];
        b_num = num_bo[i];
      end
    end
  end

  // Sweep FSM with registered beat outputs and merge-context capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      step           <= '0;
      done           <= 1'b0;
      cand_q         <= '0;
      for (int m = 0; m < N_MERGE; m++) begin
        mtype_q[m] <= '0;
        mmode_q[m] <= '0;
        maux_q[m]  <= '0;
      end
      out_if.o_valid <= 1'b0;
      out_if.o_sum   <= '0;
      out_if.o_num   <= '0;
      out_if.o_kind  <= KIND_EO;
      out_if.o_sel   <= '0;
      out_if.o_cat   <= '0;
      out_if.o_skip  <= 1'b0;
      out_if.o_last  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state          <= ST_RUN;
            out_if.o_valid <= 1'b1;
            cand_q         <= cand_bo;
            for (int m = 0; m < N_MERGE; m++) begin
              mtype_q[m] <= merge_type[m];
              mmode_q[m] <= merge_mode[m];
              maux_q[m]  <= merge_aux[m];
            end
          end
        end
        ST_RUN: begin
          if (end_en) begin
            state          <= ST_IDLE;
            out_if.o_valid <= 1'b0;
            done           <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (load_en) begin
        step          <= load_step;
        out_if.o_sum  <= b_sum;
        out_if.o_num  <= b_num;
        out_if.o_kind <= b_kind;
        out_if.o_sel  <= SEL_W'(b_sel);
        out_if.o_cat  <= CAT_W'(b_cat);
        out_if.o_skip <= b_skip;
        out_if.o_last <= b_last;
      end else if (end_en) begin
        out_if.o_sum  <= '0;
        out_if.o_num  <= '0;
        out_if.o_kind <= KIND_EO;
        out_if.o_sel  <= '0;
        out_if.o_cat  <= '0;
        out_if.o_skip <= 1'b0;
        out_if.o_last <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_sao_dist_stream.sv
// Bench for sao_dist_stream: default configuration (dut_a) and a wider
// configuration with three merge candidates and a 12-band window (dut_b),
// plus a standalone sweep of the BO remap helper.
module tb_sao_dist_stream;
  import sao_pkg::*;

  localparam int W = 36;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus state ----------------
  logic                rdy, start_a, start_b;
  logic signed [13:0]  eo_sum [4][4];
  logic [9:0]          eo_num [4][4];
  logic signed [13:0]  bo_sum [12];
  logic [9:0]          bo_num [12];
  logic [4:0]          cand;
  logic [2:0]          mt [3];
  logic [1:0]          mm [3];
  logic [4:0]          ma [3];

  logic signed [13:0]  a_bo_sum [8];
  logic [9:0]          a_bo_num [8];
  logic [2:0]          a_mt [2];
  logic [1:0]          a_mm [2];
  logic [4:0]          a_ma [2];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      a_bo_sum[i] = bo_sum[i];
      a_bo_num[i] = bo_num[i];
    end
    for (int i = 0; i < 2; i++) begin
      a_mt[i] = mt[i];
      a_mm[i] = mm[i];
      a_ma[i] = ma[i];
    end
  end

  // ---------------- DUTs ----------------
  logic busy_a, done_a, busy_b, done_b;
  sweep_state_t st_a, st_b;

  sao_dist_stream_if #(.SUM_W(14), .NUM_W(10), .SEL_W(2), .CAT_W(3)) if_a ();
  sao_dist_stream_if #(.SUM_W(14), .NUM_W(10), .SEL_W(2), .CAT_W(4)) if_b ();
  assign if_a.o_ready = rdy;
  assign if_b.o_ready = rdy;

  sao_dist_stream dut_a (
    .clk(clk), .rst(rst), .start(start_a),
    .sum_eo(eo_sum), .num_eo(eo_num), .sum_bo(a_bo_sum), .num_bo(a_bo_num),
    .cand_bo(cand), .merge_type(a_mt), .merge_mode(a_mm), .merge_aux(a_ma),
    .busy(busy_a), .done(done_a), .dbg_state(st_a), .out_if(if_a.master)
  );

  sao_dist_stream #(.N_BO_WIN(12), .N_MERGE(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b),
    .sum_eo(eo_sum), .num_eo(eo_num), .sum_bo(bo_sum), .num_bo(bo_num),
    .cand_bo(cand), .merge_type(mt), .merge_mode(mm), .merge_aux(ma),
    .busy(busy_b), .done(done_b), .dbg_state(st_b), .out_if(if_b.master)
  );

  logic [4:0] rm_cand, rm_aux;
  logic [1:0] rm_cat;
  logic       rm_hit;
  logic [2:0] rm_idx;

  sao_merge_bo_remap #(.N_BO_WIN(8), .N_CATEGORY(4)) u_rm (
    .cand_bo(rm_cand), .aux(rm_aux), .cat(rm_cat), .hit(rm_hit), .idx(rm_idx)
  );

  // ---------------- observation ----------------
  function automatic logic [W-1:0] pack(input int kind, input int sel, input int cat,
                                        input bit skip, input bit last,
                                        input int sum, input int num);
    logic [1:0]  k;
    logic [3:0]  s;
    logic [3:0]  c;
    logic [13:0] su;
    logic [9:0]  nu;
    k  = 2'(kind);
    s  = 4'(sel);
    c  = 4'(cat);
    su = 14'(sum);
    nu = 10'(num);
    return {k, s, c, skip, last, su, nu};
  endfunction

  bit use_b;
  logic [W-1:0] beat_a, beat_b, obs_beat;
  logic obs_valid, obs_busy, obs_done, obs_run;
  logic [W+3:0] obs_all, all_a, all_b;

  assign beat_a = pack(int'(if_a.o_kind), int'(if_a.o_sel), int'(if_a.o_cat), if_a.o_skip,
                       if_a.o_last, int'(if_a.o_sum), int'(if_a.o_num));
  assign beat_b = pack(int'(if_b.o_kind), int'(if_b.o_sel), int'(if_b.o_cat), if_b.o_skip,
                       if_b.o_last, int'(if_b.o_sum), int'(if_b.o_num));
  assign all_a  = {if_a.o_valid, busy_a, done_a, (st_a == ST_RUN), beat_a};
  assign all_b  = {if_b.o_valid, busy_b, done_b, (st_b == ST_RUN), beat_b};

  assign obs_beat  = use_b ? beat_b : beat_a;
  assign obs_valid = use_b ? if_b.o_valid : if_a.o_valid;
  assign obs_busy  = use_b ? busy_b : busy_a;
  assign obs_done  = use_b ? done_b : done_a;
  assign obs_run   = use_b ? (st_b == ST_RUN) : (st_a == ST_RUN);
  assign obs_all   = use_b ? all_b : all_a;

  // ---------------- scoreboard ----------------
  int n_chk = 0;
  int n_err = 0;
  logic [W-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the full ordered beat list of one sweep, from the stat tables.
  task automatic build_exp(input bit ub);
    int nbo, nm, n, k, wlo, first;
    nbo = ub ? 12 : 8;
    nm  = ub ? 3 : 2;
    n   = 16 + nbo + 4 * nm;
    wlo = nbo / 2 - 1;
    k   = 0;
    exp_q.delete();
    for (int t = 0; t < 4; t++)
      for (int c = 0; c < 4; c++) begin
        exp_q.push_back(pack(0, t, c, 0, k == n - 1, int'(eo_sum[t][c]), int'(eo_num[t][c])));
        k++;
      end
    for (int o = 0; o < nbo; o++) begin
      exp_q.push_back(pack(1, 0, o, 0, k == n - 1, int'(bo_sum[o]), int'(bo_num[o])));
      k++;
    end
    for (int m = 0; m < nm; m++)
      for (int c = 0; c < 4; c++) begin
        first = int'(ma[m]) - (int'(cand) - wlo);
        if (mm[m] == 2'd0 || int'(mt[m]) > 4)
          exp_q.push_back(pack(2, m, c, 1, k == n - 1, 0, 0));
        else if (int'(mt[m]) < 4)
          exp_q.push_back(pack(2, m, c, 0, k == n - 1,
                               int'(eo_sum[mt[m]][c]), int'(eo_num[mt[m]][c])));
        else if (first >= 0 && first + 3 <= nbo - 1)
          exp_q.push_back(pack(2, m, c, 0, k == n - 1,
                               int'(bo_sum[first + c]), int'(bo_num[first + c])));
        else
          exp_q.push_back(pack(2, m, c, 1, k == n - 1, 0, 0));
        k++;
      end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_start(input bit ub, input bit v);
    if (ub) start_b = v;
    else    start_a = v;
  endtask

  task automatic set_merge(input int m, input int ty, input int md, input int ax);
    mt[m] = 3'(ty);
    mm[m] = 2'(md);
    ma[m] = 5'(ax);
  endtask

  task automatic rand_stats();
    for (int t = 0; t < 4; t++)
      for (int c = 0; c < 4; c++) begin
        eo_sum[t][c] = 14'($urandom_range(0, 16383));
        eo_num[t][c] = 10'($urandom_range(0, 1023));
      end
    for (int i = 0; i < 12; i++) begin
      bo_sum[i] = 14'($urandom_range(0, 16383));
      bo_num[i] = 10'($urandom_range(0, 1023));
    end
  endtask

  task automatic rand_merge();
    cand = 5'($urandom_range(0, 31));
    for (int m = 0; m < 3; m++)
      set_merge(m, ($urandom_range(0, 2) == 0) ? $urandom_range(0, 7) : 4,
                $urandom_range(0, 3), int'(cand) + $urandom_range(0, 12) - 6);
  endtask

  // mode 0: ready held high; 1: alternating ready with a 5-cycle hold at
  // beat 20; 2: random ready. rst_at >= 0 resets before that beat transfers.
  task automatic run_sweep(input bit ub, input int mode, input int rst_at);
    int n, beat, cyc, hold;
    bit stalled;
    logic [W-1:0] snap;
    use_b = ub;
    build_exp(ub);
    n = exp_q.size();
    beat = 0; cyc = 0; hold = 0; stalled = 1'b0; snap = '0;
    rdy = 1'b0;
    drive_start(ub, 1'b1);
    @(posedge clk); #1;
    drive_start(ub, 1'b0);
    chk("valid_after_start", {obs_valid, obs_busy, obs_run}, 3'b111);
    while (beat < n) begin
      if (cyc > 4 * n + 50) begin
        chk("sweep_timeout", beat, n);
        return;
      end
      if (stalled) chk("stall_hold", obs_beat, snap);
      chk("in_sweep", {obs_valid, obs_done}, 2'b10);
      if (rst_at == beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_clear", obs_all, '0);
        @(posedge clk); #1;
        chk("rst_no_done", {obs_valid, obs_done, obs_busy}, 3'b000);
        exp_q.delete();
        return;
      end
      case (mode)
        0: rdy = 1'b1;
        1: if (beat == 20 && hold < 5) begin
             rdy = 1'b0;
             hold++;
           end else begin
             rdy = !cyc[0];
           end
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      drive_start(ub, (beat == 5 && mode != 0) || (beat == n - 1 && mode == 0));
      if (rdy) begin
        chk($sformatf("beat%0d", beat), obs_beat, exp_q.pop_front());
        beat++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        snap = obs_beat;
      end
      @(posedge clk); #1;
      cyc++;
    end
    drive_start(ub, 1'b0);
    rdy = 1'b0;
    chk("done_pulse", {obs_done, obs_valid, obs_busy}, 3'b100);
    if (mode == 0) chk("sweep_cycles", cyc, n);
    @(posedge clk); #1;
    chk("done_one_cycle", {obs_done, obs_valid, obs_busy}, 3'b000);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int first, eh, ei;
    rst = 1'b1; rdy = 1'b0; start_a = 1'b0; start_b = 1'b0; use_b = 1'b0;
    cand = '0; rm_cand = '0; rm_aux = '0; rm_cat = '0;
    for (int m = 0; m < 3; m++) set_merge(m, 0, 0, 0);
    for (int t = 0; t < 4; t++)
      for (int c = 0; c < 4; c++) begin
        eo_sum[t][c] = 14'(16 * t + c);
        eo_num[t][c] = 10'(17 * (4 * t + c) + 3);
      end
    for (int i = 0; i < 12; i++) begin
      bo_sum[i] = 14'(100 + i);
      bo_num[i] = 10'(300 + i);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", all_a, '0);
    chk("reset_b", all_b, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_a", all_a, '0);

    // Remap helper, every cand/aux/category combination.
    for (int cb = 0; cb < 32; cb++)
      for (int ax = 0; ax < 32; ax++)
        for (int c = 0; c < 4; c++) begin
          rm_cand = 5'(cb); rm_aux = 5'(ax); rm_cat = 2'(c);
          #1;
          first = ax - (cb - 3);
          eh = (first >= 0 && first + 3 <= 7) ? 1 : 0;
          ei = (eh != 0) ? first + c : 0;
          chk($sformatf("remap c%0d a%0d k%0d", cb, ax, c),
              {rm_hit, rm_hit ? rm_idx : 3'd0}, {1'(eh), 3'(ei)});
        end

    // Ordered sweep, no merges, ready held high.
    run_sweep(1'b0, 0, -1);

    // BO merges inside the window, toggling ready with a long stall.
    rand_stats();
    cand = 5'd10; set_merge(0, 4, 1, 7); set_merge(1, 4, 1, 11);
    run_sweep(1'b0, 1, -1);
    // Just outside the window on both sides.
    set_merge(0, 4, 2, 6); set_merge(1, 4, 3, 12);
    run_sweep(1'b0, 2, -1);
    // Low edge without underflow, then a far band that must not wrap.
    cand = 5'd1; set_merge(0, 4, 1, 0); set_merge(1, 4, 1, 3);
    run_sweep(1'b0, 0, -1);
    cand = 5'd0; set_merge(0, 4, 1, 31); set_merge(1, 4, 1, 0);
    run_sweep(1'b0, 2, -1);
    // EO merge, invalid type, mode 0.
    set_merge(0, 2, 1, 0); set_merge(1, 5, 1, 0);
    run_sweep(1'b0, 1, -1);
    set_merge(0, 3, 2, 0); set_merge(1, 1, 0, 0);
    run_sweep(1'b0, 2, -1);

    // Reset mid-sweep, then a complete sweep.
    rand_stats(); rand_merge();
    run_sweep(1'b0, 2, 12);
    run_sweep(1'b0, 0, -1);

    // Wide configuration.
    for (int r = 0; r < 3; r++) begin
      rand_stats(); rand_merge();
      run_sweep(1'b1, 2, -1);
    end
    run_sweep(1'b1, 2, 12);
    rand_merge();
    run_sweep(1'b1, 0, -1);
    run_sweep(1'b1, 1, -1);

    // Random sweeps on the default configuration.
    for (int r = 0; r < 4; r++) begin
      rand_stats(); rand_merge();
      run_sweep(1'b0, 2, -1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/sao_dist_stream.md
# sao_dist_stream

Parametrised, sequential successor to the SAO decision distortion arranger. After a `start` pulse it walks every distortion candidate: EO class × category, the BO band window around `cand_bo`, and N_MERGE merge candidates × category. For each it emits one (sum, num) pair on a valid/ready stream to the SAO RD-cost datapath. It sits between the CTU statistics accumulator and the SAO decision engine, and replaces free-running `cnt_dc` indexing with an internal counter, backpressure, per-beat tags and captured merge context.

## Interface
- NUM_PIX_CTU_LOG2, 5: log2 of the CTU side; NUM_W = 2*NUM_PIX_CTU_LOG2 bits for counts.
- DIFF_CLIP_BIT, 4: clip width of a pixel difference; SUM_W = NUM_W+DIFF_CLIP_BIT bits, signed.
- N_CATEGORY, 4: offsets per EO class and per merge candidate.
- N_EO_TYPE, 4: number of EO classes.
- N_BO_WIN, 8: BO bands held around `cand_bo` (even, ≥ N_CATEGORY).
- N_MERGE, 2: merge candidates; 0 = left, 1 = up, 2+ = extra (e.g. temporal).
- N_STEP, derived: N_EO_TYPE*N_CATEGORY + N_BO_WIN + N_MERGE*N_CATEGORY (32 with defaults).
- clk in 1: clock.
- rst in 1: reset, synchronous, active-high.
- start in 1: one-cycle request to start a sweep; ignored while busy.
- sum_eo in SUM_W signed [N_EO_TYPE][N_CATEGORY]; num_eo in NUM_W [N_EO_TYPE][N_CATEGORY]: EO statistics.
- sum_bo in SUM_W signed [N_BO_WIN]; num_bo in NUM_W [N_BO_WIN]: BO window statistics.
- cand_bo in 5: centre band for the BO window.
- merge_type in 3 [N_MERGE]; merge_mode in 2 [N_MERGE]; merge_aux in 5 [N_MERGE]: per-candidate neighbour SAO parameters.
- busy out 1: a sweep is in progress.
- o_valid out 1; o_ready in 1: output handshake.
- o_sum out SUM_W signed; o_num out NUM_W: beat payload.
- o_kind out 2: 0 EO, 1 BO, 2 MERGE.
- o_sel out clog2(max(N_EO_TYPE,N_MERGE,2)): EO class or merge candidate number.
- o_cat out clog2(N_BO_WIN): category, or band offset within the window for BO beats.
- o_skip out 1: merge beat is unusable; payload is zero.
- o_last out 1: final beat of the sweep.
- done out 1: one-cycle pulse after the last beat is accepted.

## Operation
- FSM has states IDLE and RUN.
- IDLE → RUN when `start` is high. On that edge: step ← 0; `cand_bo`, `merge_*` are captured into registers; o_valid ← 1 with beat 0 loaded.
- `sum_*`/`num_*` are not captured. The upstream block holds them stable from `start` until `done`.
- In RUN, a beat transfers on o_valid & o_ready. Then step increments and the next beat is loaded the same edge.
- Step ranges:
  - [0, N_EO_TYPE*N_CATEGORY): EO beat; sel = step/N_CATEGORY, cat = step%N_CATEGORY.
  - Next N_BO_WIN steps: BO beat; cat = offset.
  - Remaining steps: MERGE beat; sel = candidate, cat = category.
- Merge beat for candidate m, category c:
  - If mode==0 or type>N_EO_TYPE: skip.
  - Else if type<N_EO_TYPE: payload = eo[type][c].
  - Else (type==N_EO_TYPE, BO): W_LO = N_BO_WIN/2-1; d = aux − cand_bo. Compute in 7-bit signed arithmetic; no unsigned wrap.
  - BO case is valid iff −W_LO ≤ d ≤ N_BO_WIN−W_LO−N_CATEGORY. Then payload = bo[W_LO+d+c]; otherwise skip.
- Transfer with o_last=1 → IDLE; o_valid ← 0; done ← 1 for one cycle.

## Timing
- Reset state: IDLE. All outputs 0: busy, o_valid, o_sum, o_num, o_kind, o_sel, o_cat, o_skip, o_last, done.
- Latency: `start` at edge k gives o_valid=1 in cycle k+1.
- Minimum sweep is N_STEP cycles with o_ready held high. `done` asserts in the cycle after the last transfer.
- While o_valid && !o_ready, every output stays stable. There is no combinational path from o_ready to any output.
- `start` in the same cycle as the final transfer is ignored. A new start is accepted only from IDLE, so a new sweep needs a fresh pulse after `done`.
- `rst` mid-sweep: next cycle is IDLE with all outputs 0. No `done` is issued.
- busy = (state==RUN).

## Structure
- Package `sao_pkg` holds:
  - the kind enum (EO/BO/MERGE);
  - SAO type encodings (EO0..EO3, BO=N_EO_TYPE);
  - NUM_W/SUM_W width functions;
  - W_LO derivation.
- Sub-module `sao_merge_bo_remap` (combinational) computes the window check and BO index from cand_bo, aux and c, and outputs {hit, idx}. Verify it standalone.

## Test plan
- Defaults, o_ready=1, each sum_eo[t][c]=16t+c, each num unique, no merges: 32 beats in order; beat 16 is BO offset 0; o_last on beat 31; done in cycle 33.
- o_ready toggles 1010… plus a 5-cycle low hold at beat 20: no beat is lost or duplicated, and outputs are stable during every stall.
- Merge BO with cand_bo=10: aux 7 and aux 11 → hit, idx 0 and 4 at c=0. Aux 6 and aux 12 → o_skip=1, payload 0.
- cand_bo=1, aux=0: hit with idx 2, no underflow. cand_bo=0, aux=31: skip.
- Merge EO type 2 → payload eo[2][c]. Type 5 or mode 0 → skip. Start pulse mid-sweep is ignored.
- rst at beat 12 → outputs 0 next cycle, no done; a new start then runs a full sweep. Repeat with N_MERGE=3, N_BO_WIN=12 → 40 beats.
